// File: rtl/exu_cdb_txq_pkg.sv
// ---------------------------------------------------------------------------
// exu_cdb_txq_pkg
//   Types and default widths shared by the CDB producer queues, the CDB
//   arbiter and the exu2cdb_itf interface.
//   No ports (package).
// ---------------------------------------------------------------------------
package exu_cdb_txq_pkg;

  // Default widths of a CDB broadcast
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  // One queued result at the default widths
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_entry_t;

endpackage

// File: rtl/exu2cdb_itf.sv
// ---------------------------------------------------------------------------
// exu2cdb_itf
//   Link from one execution unit's result queue to the CDB arbiter.
//   Members:
//     req   - producer has a valid head entry
//     tag   - head entry destination tag
//     wdata - head entry result data
//     rdy   - arbiter grant; a transfer happens when req && rdy
//   Modports: exu (producer side), arb (arbiter side).
// ---------------------------------------------------------------------------
interface exu2cdb_itf #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              req;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] wdata;
  logic              rdy;

  modport exu (output req, output tag, output wdata, input rdy);
  modport arb (input req, input tag, input wdata, output rdy);
endinterface

// File: rtl/exu_cdb_txq_ctrl.sv
// ---------------------------------------------------------------------------
// exu_cdb_txq_ctrl
//   Pointer / occupancy bookkeeping for the CDB result queue.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     flush_i       - drop all entries (pointers and count back to zero)
//     push_req_i    - producer offers a result
//     pop_req_i     - arbiter grant for the head entry
//     push_en_o     - result is accepted this cycle (write the array)
//     pop_en_o      - head entry leaves this cycle
//     wr_ptr_o      - slot written on push
//     rd_ptr_o      - current head slot
//     full_o        - no free slot (drives res_ready low)
//     empty_o       - no valid entry (drives req low)
// ---------------------------------------------------------------------------
module exu_cdb_txq_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic             push_en_o,
  output logic             pop_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Flags come from registered state only, so a combinational grant can
  // never reach res_ready.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full queue refuses the push even when the head leaves the same cycle.
  assign push_en_o = push_req_i && !full_o && !flush_i;
  assign pop_en_o  = pop_req_i  && !empty_o;

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en_o, pop_en_o})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/exu_cdb_txq.sv
// ---------------------------------------------------------------------------
// exu_cdb_txq
//   In-order result queue between one functional unit and the CDB arbiter.
//   Results are accepted on res_valid && res_ready and presented, oldest
//   first, as req/tag/wdata on the exu side of exu2cdb_itf. A result is
//   visible the cycle after it is pushed (no bypass).
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     flush       - drop every queued result (overrides push and pop)
//     res_valid   - FU presents a completed result
//     res_tag     - destination tag of that result
//     res_wdata   - result data
//     res_ready   - queue can take a result this cycle
//     cdb_tx_itf  - req/tag/wdata out, rdy (grant) in
// ---------------------------------------------------------------------------
module exu_cdb_txq
  import exu_cdb_txq_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              res_valid,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic [DATA_W-1:0] res_wdata,
  output logic              res_ready,
  exu2cdb_itf.exu           cdb_tx_itf
);

  localparam int PTR_W = $clog2(DEPTH);

  // Same layout as cdb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  logic             push_en;
  logic             pop_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             req;
  entry_t           head;

  // Data array is not reset; stale contents are hidden by req below.
  entry_t mem_q [DEPTH];

  exu_cdb_txq_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_req_i (res_valid),
    .pop_req_i  (cdb_tx_itf.rdy),
    .push_en_o  (push_en),
    .pop_en_o   (pop_en),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr] <= '{tag: res_tag, wdata: res_wdata};
    end
  end

  assign req       = !empty;
  assign head      = mem_q[rd_ptr];
  assign res_ready = !full;

  // Head only changes on a pop or flush, so tag/wdata stay put while the
  // arbiter holds off rdy.
  assign cdb_tx_itf.req   = req;
  assign cdb_tx_itf.tag   = req ? head.tag   : '0;
  assign cdb_tx_itf.wdata = req ? head.wdata : '0;

endmodule

// File: tb/tb_exu_cdb_txq.sv
module tb_exu_cdb_txq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [31:0] res_wdata;
  logic        res_ready;

  exu2cdb_itf #(.TAG_W(4), .DATA_W(32)) itf ();

  exu_cdb_txq #(.TAG_W(4), .DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .res_wdata  (res_wdata),
    .res_ready  (res_ready),
    .cdb_tx_itf (itf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        vld;
    logic [3:0]  tag;
    logic [31:0] wd;
    logic        rdy;
    logic        e_req;
    logic [3:0]  e_tag;
    logic [31:0] e_wd;
    logic        e_ready;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic fl, logic vld, logic [3:0] tag, logic [31:0] wd, logic rdy,
                              logic e_req, logic [3:0] e_tag, logic [31:0] e_wd, logic e_ready);
    vec_t v;
    v.fl = fl; v.vld = vld; v.tag = tag; v.wd = wd; v.rdy = rdy;
    v.e_req = e_req; v.e_tag = e_tag; v.e_wd = e_wd; v.e_ready = e_ready;
    return v;
  endfunction

  // Compare all four outputs against expectations; one line per vector.
  task automatic check_outs(string name, logic e_req, logic [3:0] e_tag, logic [31:0] e_wd,
                            logic e_ready);
    n_vec++;
    if (itf.req !== e_req) begin
      n_err++;
      $display("FAIL %s req: got %b expected %b", name, itf.req, e_req);
    end
    if (itf.tag !== e_tag) begin
      n_err++;
      $display("FAIL %s tag: got %0h expected %0h", name, itf.tag, e_tag);
    end
    if (itf.wdata !== e_wd) begin
      n_err++;
      $display("FAIL %s wdata: got %08h expected %08h", name, itf.wdata, e_wd);
    end
    if (res_ready !== e_ready) begin
      n_err++;
      $display("FAIL %s res_ready: got %b expected %b", name, res_ready, e_ready);
    end
    $display("%s: req=%b tag=%0h wdata=%08h res_ready=%b", name, itf.req, itf.tag, itf.wdata,
             res_ready);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- vector table: inputs applied this cycle, outputs expected before the edge
    // single pass
    tbl[0]  = mk(0, 1, 4'd3,  32'hDEADBEEF, 1,  0, 4'd0,  32'h0,        1);
    tbl[1]  = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd3,  32'hDEADBEEF, 1);
    tbl[2]  = mk(0, 0, 4'd0,  32'h0,        0,  0, 4'd0,  32'h0,        1);
    // back-pressure: fill, refused 5th, drain in order
    tbl[3]  = mk(0, 1, 4'd1,  32'h11,       0,  0, 4'd0,  32'h0,        1);
    tbl[4]  = mk(0, 1, 4'd2,  32'h22,       0,  1, 4'd1,  32'h11,       1);
    tbl[5]  = mk(0, 1, 4'd3,  32'h33,       0,  1, 4'd1,  32'h11,       1);
    tbl[6]  = mk(0, 1, 4'd4,  32'h44,       0,  1, 4'd1,  32'h11,       1);
    tbl[7]  = mk(0, 1, 4'd5,  32'h55,       0,  1, 4'd1,  32'h11,       0);
    tbl[8]  = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd1,  32'h11,       0);
    tbl[9]  = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd2,  32'h22,       1);
    tbl[10] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd3,  32'h33,       1);
    tbl[11] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd4,  32'h44,       1);
    tbl[12] = mk(0, 0, 4'd0,  32'h0,        1,  0, 4'd0,  32'h0,        1);
    // full + simultaneous push/pop, then continuous push/pop at count 3
    tbl[13] = mk(0, 1, 4'd8,  32'h80,       0,  0, 4'd0,  32'h0,        1);
    tbl[14] = mk(0, 1, 4'd9,  32'h90,       0,  1, 4'd8,  32'h80,       1);
    tbl[15] = mk(0, 1, 4'd10, 32'hA0,       0,  1, 4'd8,  32'h80,       1);
    tbl[16] = mk(0, 1, 4'd11, 32'hB0,       0,  1, 4'd8,  32'h80,       1);
    tbl[17] = mk(0, 1, 4'd12, 32'hC0,       1,  1, 4'd8,  32'h80,       0);
    tbl[18] = mk(0, 1, 4'd12, 32'hC0,       1,  1, 4'd9,  32'h90,       1);
    tbl[19] = mk(0, 1, 4'd13, 32'hD0,       1,  1, 4'd10, 32'hA0,       1);
    tbl[20] = mk(0, 1, 4'd14, 32'hE0,       1,  1, 4'd11, 32'hB0,       1);
    tbl[21] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd12, 32'hC0,       1);
    tbl[22] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd13, 32'hD0,       1);
    tbl[23] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd14, 32'hE0,       1);
    tbl[24] = mk(0, 0, 4'd0,  32'h0,        0,  0, 4'd0,  32'h0,        1);
    // flush with 3 queued and a same-cycle push of tag 7
    tbl[25] = mk(0, 1, 4'd1,  32'h1,        0,  0, 4'd0,  32'h0,        1);
    tbl[26] = mk(0, 1, 4'd2,  32'h2,        0,  1, 4'd1,  32'h1,        1);
    tbl[27] = mk(0, 1, 4'd3,  32'h3,        0,  1, 4'd1,  32'h1,        1);
    tbl[28] = mk(1, 1, 4'd7,  32'h77,       1,  1, 4'd1,  32'h1,        1);
    tbl[29] = mk(0, 0, 4'd0,  32'h0,        1,  0, 4'd0,  32'h0,        1);
    tbl[30] = mk(0, 0, 4'd0,  32'h0,        1,  0, 4'd0,  32'h0,        1);
    // queue usable again after flush
    tbl[31] = mk(0, 1, 4'd5,  32'h55,       0,  0, 4'd0,  32'h0,        1);
    tbl[32] = mk(0, 0, 4'd0,  32'h0,        1,  1, 4'd5,  32'h55,       1);
    tbl[33] = mk(0, 0, 4'd0,  32'h0,        1,  0, 4'd0,  32'h0,        1);

    // ---- reset, idle
    rst = 1'b1; flush = 1'b0; res_valid = 1'b0; res_tag = '0; res_wdata = '0; itf.rdy = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_outs("reset", 1'b0, 4'd0, 32'h0, 1'b1);
    rst = 1'b0;
    next_cycle();

    // ---- table
    for (int i = 0; i < NV; i++) begin
      flush = tbl[i].fl; res_valid = tbl[i].vld; res_tag = tbl[i].tag;
      res_wdata = tbl[i].wd; itf.rdy = tbl[i].rdy;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_tag, tbl[i].e_wd, tbl[i].e_ready);
      next_cycle();
    end
    flush = 1'b0; res_valid = 1'b0;

    // ---- wrap: tags 0..9 with rdy toggling, scoreboard model
    begin
      int sb[$];
      int next_push = 0;
      int got = 0;
      logic e_req, e_ready;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
        res_valid = (next_push < 10);
        res_tag   = 4'(next_push);
        res_wdata = 32'h1000 + 32'(next_push);
        itf.rdy   = (cyc % 2 == 0);
        @(negedge clk);
        e_req   = (sb.size() != 0);
        e_ready = (sb.size() != 4);
        if (e_req)
          check_outs($sformatf("wrap%0d", cyc), 1'b1, 4'(sb[0]), 32'h1000 + 32'(sb[0]), e_ready);
        else
          check_outs($sformatf("wrap%0d", cyc), 1'b0, 4'd0, 32'h0, e_ready);
        @(posedge clk);
        if (e_req && itf.rdy) begin
          void'(sb.pop_front());
          got++;
        end
        if (res_valid && e_ready) begin
          sb.push_back(next_push);
          next_push++;
        end
        #1;
      end
      n_vec++;
      if (got != 10) begin
        n_err++;
        $display("FAIL wrap_count: got %0d results expected 10", got);
      end
      res_valid = 1'b0; itf.rdy = 1'b1;
      @(negedge clk);
      check_outs("wrap_drained", 1'b0, 4'd0, 32'h0, 1'b1);
      next_cycle();
    end

    // ---- reset mid-operation with a same-cycle push
    itf.rdy = 1'b0; res_valid = 1'b1; res_tag = 4'd6; res_wdata = 32'h66;
    next_cycle();
    res_tag = 4'd9; res_wdata = 32'h99;
    @(negedge clk);
    check_outs("pre_rst", 1'b1, 4'd6, 32'h66, 1'b1);
    next_cycle();
    rst = 1'b1; res_tag = 4'd2; res_wdata = 32'h22;
    next_cycle();
    rst = 1'b0; res_valid = 1'b0; itf.rdy = 1'b1;
    @(negedge clk);
    check_outs("mid_rst", 1'b0, 4'd0, 32'h0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_outs("post_rst", 1'b0, 4'd0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
